// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
// Time-multiplexed N-digit 7-segment driver. A load strobe captures the hex
// word and per-digit DP/blank/blink masks into shadow registers; the scanner
// then walks the digits, decoding one nibble at a time into registered
// segment, decimal-point and anode outputs.
//
// Interface handshake: load is a single-cycle capture strobe with no ready.
// Whenever load is high at a rising clk edge (and rst is low) the
// value/dp_in/blank_mask/blink_mask inputs are taken. Every cycle is
// accepted, and there is no back-pressure.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000,
  parameter int ACTIVE_LOW  = 1,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Inactive pin levels. XOR-ing an active-high pattern with these gives the
  // pin pattern for either polarity.
  localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic [NUM_DIGITS-1:0]   shadow_blink;

  logic [DIV_W-1:0] div_cnt;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;
  logic [IDX_W-1:0] idx;

  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_blink;
  logic                  dark;
  logic [6:0]            seg_on;
  logic                  dp_on;
  logic [NUM_DIGITS-1:0] an_on;

  // Hex glyph table, active-high GFEDCBA.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  // Shadow registers: capture the display contents on load, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      shadow_blink <= '0;
    end else if (load) begin
      shadow_value <= value;
      shadow_dp    <= dp_in;
      shadow_blank <= blank_mask;
      shadow_blink <= blink_mask;
    end
  end

  // Refresh divider: advance the scanned digit once per REFRESH_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      if (idx == IDX_LAST) begin
        idx <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Blink timer: flip the blink phase every BLINK_DIV cycles (0 = on, 1 = off).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Select the shadow fields of the digit currently being scanned.
  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_blink  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nibble = shadow_value[4*k +: 4];
        cur_dp     = shadow_dp[k];
        cur_blank  = shadow_blank[k];
        cur_blink  = shadow_blink[k];
      end
    end
  end

  // Active-high drive pattern for the selected digit; all off when dark.
  always_comb begin
    dark   = cur_blank | (cur_blink & blink_phase);
    seg_on = dark ? 7'h00 : decode(cur_nibble);
    dp_on  = ~dark & cur_dp;
    an_on  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_on[k] = (idx == IDX_W'(k)) & ~dark;
    end
  end

  // Output register: pins change together on one edge, so the anode and
  // segment pattern always refer to the same digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg       <= SEG_OFF;
      dp        <= DP_OFF;
      an        <= AN_OFF;
      digit_idx <= '0;
    end else begin
      seg       <= seg_on ^ SEG_OFF;
      dp        <= dp_on ^ DP_OFF;
      an        <= an_on ^ AN_OFF;
      digit_idx <= idx;
    end
  end

endmodule
